store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the number of store entries; legal values are 2, 4 and 8.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port st_valid, input, 1 bit: a store is offered.
REQ-005 SHALL have ports st_addr input 32, st_wdata input 32 and st_mode input 3, carrying the store byte address, data and mem_mode.
REQ-006 SHALL have port st_ready, output, 1 bit: the buffer can accept a store.
REQ-007 SHALL have ports ld_valid input 1, ld_addr input 32 and ld_mode input 3, carrying the load probe from the MEM stage.
REQ-008 SHALL have port ld_stall, output, 1 bit: the load must wait for pending stores to drain.
REQ-009 SHALL have ports fwd_valid output 1 and fwd_data output 32, carrying the forwarded load result.
REQ-010 SHALL have port mem_busy, input, 1 bit: the data-memory port is used by a load this cycle.
REQ-011 SHALL have ports mem_wr_en output 1, mem_addr output 32, mem_wdata output 32 and mem_mode output 3, driving the data-memory write port.
REQ-012 SHALL have port count, output, 4 bits: the number of occupied entries.

Function
REQ-013 SHALL use the mem_mode encodings Byte=000, HalfWord=001, Word=010, U_Byte=011 and U_HalfWord=100.
REQ-014 SHALL hold the entries in FIFO order, with the head being the oldest entry.
REQ-015 SHALL drive st_ready as (count != DEPTH), combinationally, with no dependence on a same-cycle drain.
REQ-016 SHALL enqueue {st_addr, st_wdata, st_mode} at the clock edge when st_valid && st_ready and st_mode is in {000, 001, 010}.
REQ-017 SHALL complete the handshake for a store with any other st_mode but enqueue nothing.
REQ-018 SHALL, when count != 0 && !mem_busy && !rst, drive mem_wr_en=1 with mem_addr, mem_wdata and mem_mode taken from the head entry, and pop the head at that edge.
REQ-019 SHALL, in every other cycle, drive mem_wr_en=0 and drive mem_addr, mem_wdata and mem_mode to 0.
REQ-020 SHALL have latency such that a store enqueued at edge N into an empty buffer appears on the memory port during cycle N+1, provided mem_busy=0.
REQ-021 SHALL, on a simultaneous enqueue and pop, keep count unchanged, with the pointers advancing modulo DEPTH.
REQ-022 SHALL define access size as 1 byte for modes 000/011, 2 bytes for 001/100 and 4 bytes for 010.
REQ-023 SHALL compute byte range ends as addr+size-1 in 33 bits, with no wrap past 0xFFFFFFFF.
REQ-024 SHALL flag an entry as overlapping when ld_valid is high and the load byte range intersects that entry's range.
REQ-025 SHALL drive ld_stall=1 combinationally when any entry overlaps and forwarding is not possible, and 0 otherwise, including when ld_valid=0.
REQ-026 SHALL drain stores during a stall whenever mem_busy=0.
REQ-027 SHALL drive fwd_valid=0 and fwd_data=0 whenever forwarding is not active.

Reset
REQ-028 SHALL, on rst=1 at an edge, set count to 0, set the head and tail pointers to 0, and discard all entries; entry storage need not be cleared.
REQ-029 SHALL, while rst=1, force mem_wr_en=0, ld_stall=0 and fwd_valid=0, and ignore any offered store.
REQ-030 SHALL, after reset, present st_ready=1, count=0 and all memory outputs at 0.

Configuration
REQ-031 SHALL enable store-to-load forwarding only when the macro STORE_BUF_FWD_EN is defined.
REQ-032 SHALL, with STORE_BUF_FWD_EN defined, forward when the youngest overlapping entry has addr == ld_addr and a size >= the load size.
REQ-033 SHALL, when forwarding, drive fwd_valid=1, ld_stall=0 and fwd_data from the entry data: sign-extended for Byte/HalfWord, zero-extended for U_Byte/U_HalfWord, and full for Word.
REQ-034 SHALL, with STORE_BUF_FWD_EN defined, stall on any other overlap.
REQ-035 SHALL, without STORE_BUF_FWD_EN, tie fwd_valid=0 and fwd_data=0 and stall on any overlap.

Verification
REQ-036 SHALL cover a fill test: 5 Word stores with DEPTH=4 and mem_busy=1 -> st_ready=0 after the 4th store, the 5th is held, and count=4.
REQ-037 SHALL cover drain order: a buffer holding stores to 0x10, 0x14 and 0x18 with mem_busy released -> mem_wr_en high for 3 consecutive cycles with mem_addr 0x10, 0x14, 0x18 and count reaching 0.
REQ-038 SHALL cover overlap stall: a pending HalfWord store at 0x21 and a Byte load at 0x22 -> ld_stall=1; a Byte load at 0x23 -> ld_stall=0.
REQ-039 SHALL cover forwarding with STORE_BUF_FWD_EN: a pending Word store 0x000080F0 at 0x40 and a Byte load at 0x40 -> fwd_valid=1 with fwd_data=0xFFFFFFF0; a U_Byte load -> fwd_data=0x000000F0.
REQ-040 SHALL cover reset mid-drain: count=3 with rst=1 for one edge -> count=0 and no further mem_wr_en.
REQ-041 SHALL cover an invalid mode: a store with st_mode=011 accepted -> count unchanged and no memory write.

Source files
------------

// File: rtl/store_buffer.sv
// FIFO store buffer between the pipeline and the data-memory write port.
// Define STORE_BUF_FWD_EN to enable store-to-load forwarding; otherwise loads stall on any overlap.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_wdata,
  input  logic [2:0]  st_mode,
  output logic        st_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_mode,
  output logic        ld_stall,
  output logic        fwd_valid,
  output logic [31:0] fwd_data,
  input  logic        mem_busy,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_mode,
  output logic [3:0]  count
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    MODE_BYTE   = 3'b000,
    MODE_HALF   = 3'b001,
    MODE_WORD   = 3'b010,
    MODE_UBYTE  = 3'b011,
    MODE_UHALF  = 3'b100
  } mem_mode_e;

  function automatic logic [32:0] accessSize(input logic [2:0] m);
    case (m)
      MODE_HALF, MODE_UHALF: return 33'd2;
      MODE_WORD:             return 33'd4;
      default:               return 33'd1;
    endcase
  endfunction

  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [2:0]    mode_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [3:0]    count_q, count_d;
  logic          push, pop;

  assign st_ready = (count_q != 4'(DEPTH));
  assign push     = !rst && st_valid && st_ready &&
                    (st_mode inside {MODE_BYTE, MODE_HALF, MODE_WORD});
  assign pop      = !rst && (count_q != 4'd0) && !mem_busy;
  assign count    = count_q;

  always_comb begin
    head_d  = pop  ? head_q + PW'(1) : head_q;
    tail_d  = push ? tail_q + PW'(1) : tail_q;
    count_d = count_q + {3'b000, push} - {3'b000, pop};
  end

  // Entry storage is not reset; only the pointers and occupancy decide validity.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) begin
        addr_q[tail_q] <= st_addr;
        data_q[tail_q] <= st_wdata;
        mode_q[tail_q] <= st_mode;
      end
    end
  end

  always_comb begin
    mem_wr_en = pop;
    mem_addr  = pop ? addr_q[head_q] : '0;
    mem_wdata = pop ? data_q[head_q] : '0;
    mem_mode  = pop ? mode_q[head_q] : '0;
  end

  logic [32:0]   ldEnd, entEnd;
  logic [PW-1:0] idx;
  logic          anyOverlap;
`ifdef STORE_BUF_FWD_EN
  logic [PW-1:0] youngIdx;
`endif

  // Walk from oldest to youngest so the last hit is the youngest overlapping entry.
  always_comb begin
    ldEnd      = {1'b0, ld_addr} + accessSize(ld_mode) - 33'd1;
    anyOverlap = 1'b0;
    idx        = '0;
    entEnd     = '0;
`ifdef STORE_BUF_FWD_EN
    youngIdx   = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx    = head_q + PW'(i);
      entEnd = {1'b0, addr_q[idx]} + accessSize(mode_q[idx]) - 33'd1;
      if (ld_valid && (4'(i) < count_q) &&
          ({1'b0, ld_addr} <= entEnd) && ({1'b0, addr_q[idx]} <= ldEnd)) begin
        anyOverlap = 1'b1;
`ifdef STORE_BUF_FWD_EN
        youngIdx   = idx;
`endif
      end
    end
  end

`ifdef STORE_BUF_FWD_EN
  logic        canFwd;
  logic [31:0] youngData, fwdWord;

  always_comb begin
    canFwd    = anyOverlap && (addr_q[youngIdx] == ld_addr) &&
                (accessSize(mode_q[youngIdx]) >= accessSize(ld_mode));
    youngData = data_q[youngIdx];
    case (ld_mode)
      MODE_BYTE:  fwdWord = {{24{youngData[7]}}, youngData[7:0]};
      MODE_UBYTE: fwdWord = {24'h0, youngData[7:0]};
      MODE_HALF:  fwdWord = {{16{youngData[15]}}, youngData[15:0]};
      MODE_UHALF: fwdWord = {16'h0, youngData[15:0]};
      MODE_WORD:  fwdWord = youngData;
      default:    fwdWord = '0;
    endcase
  end

  assign fwd_valid = !rst && canFwd;
  assign fwd_data  = fwd_valid ? fwdWord : '0;
  assign ld_stall  = !rst && anyOverlap && !canFwd;
`else
  assign fwd_valid = 1'b0;
  assign fwd_data  = '0;
  assign ld_stall  = !rst && anyOverlap;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Randomized and directed bench for store_buffer against a queue-based reference model.
// Forwarding expectations follow STORE_BUF_FWD_EN, matching how the DUT is built.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic [2:0]  st_mode;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [2:0]  ld_mode;
  logic        ld_stall;
  logic        fwd_valid;
  logic [31:0] fwd_data;
  logic        mem_busy;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_mode;
  logic [3:0]  count;

  int nChecks = 0;
  int nFails  = 0;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_wdata(st_wdata), .st_mode(st_mode),
    .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_mode(ld_mode),
    .ld_stall(ld_stall), .fwd_valid(fwd_valid), .fwd_data(fwd_data),
    .mem_busy(mem_busy),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mode(mem_mode),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  mode;
  } entry_t;

  entry_t model[$];

  logic        eReady, eWr, eStall, eFv;
  logic [31:0] eAddr, eData, eFd;
  logic [2:0]  eMode;
  int          eCount;

  function automatic longint unsigned sizeOf(input logic [2:0] m);
    if (m == 3'b010) return 4;
    if (m == 3'b001 || m == 3'b100) return 2;
    return 1;
  endfunction

  function automatic logic [31:0] loadValue(input logic [31:0] d, input logic [2:0] m);
    case (m)
      3'b000:  return 32'($signed(d[7:0]));
      3'b001:  return 32'($signed(d[15:0]));
      3'b011:  return d % 32'd256;
      3'b100:  return d % 32'd65536;
      default: return d;
    endcase
  endfunction

  // Expected outputs for the current inputs and model contents.
  task automatic predict();
    longint unsigned ls, le, es, ee;
    int hit;
    eCount = model.size();
    eReady = (model.size() < DEPTH);
    eWr = 1'b0; eAddr = '0; eData = '0; eMode = '0;
    if (!rst && model.size() != 0 && !mem_busy) begin
      eWr = 1'b1; eAddr = model[0].addr; eData = model[0].data; eMode = model[0].mode;
    end
    eStall = 1'b0; eFv = 1'b0; eFd = '0;
    hit = -1;
    ls = longint'(ld_addr);
    le = ls + sizeOf(ld_mode) - 1;
    if (!rst && ld_valid) begin
      for (int k = model.size() - 1; k >= 0; k--) begin
        es = longint'(model[k].addr);
        ee = es + sizeOf(model[k].mode) - 1;
        if (ls <= ee && es <= le) begin
          hit = k;
          break;
        end
      end
    end
    if (hit >= 0) begin
`ifdef STORE_BUF_FWD_EN
      if (model[hit].addr == ld_addr && sizeOf(model[hit].mode) >= sizeOf(ld_mode)) begin
        eFv = 1'b1;
        eFd = loadValue(model[hit].data, ld_mode);
      end else begin
        eStall = 1'b1;
      end
`else
      eStall = 1'b1;
`endif
    end
  endtask

  // Advance one clock and apply the same edge to the model.
  task automatic clockEdge();
    entry_t e;
    bit doPush, doPop;
    @(posedge clk);
    if (rst) begin
      model.delete();
    end else begin
      doPush = st_valid && (model.size() < DEPTH) && (st_mode <= 3'b010);
      doPop  = (model.size() != 0) && !mem_busy;
      if (doPop) void'(model.pop_front());
      if (doPush) begin
        e.addr = st_addr; e.data = st_wdata; e.mode = st_mode;
        model.push_back(e);
      end
    end
    #1;
  endtask

  task automatic idleInputs();
    st_valid = 1'b0; st_addr = '0; st_wdata = '0; st_mode = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_mode = '0;
  endtask

  task automatic doReset();
    idleInputs();
    rst = 1'b1;
    clockEdge();
    rst = 1'b0;
  endtask

  task automatic pushStore(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m);
    st_valid = 1'b1; st_addr = a; st_wdata = d; st_mode = m;
    clockEdge();
    st_valid = 1'b0;
  endtask

  task automatic test_reset();
    idleInputs();
    mem_busy = 1'b0;
    rst = 1'b1;
    st_valid = 1'b1; st_addr = 32'h44; st_wdata = 32'h1234; st_mode = 3'b010;
    clockEdge();
    clockEdge();
    @(negedge clk);
    nChecks++;
    if (mem_wr_en !== 1'b0 || ld_stall !== 1'b0 || fwd_valid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset_forced: wr=%b stall=%b fwd=%b required 0/0/0", mem_wr_en, ld_stall, fwd_valid);
    end
    rst = 1'b0;
    idleInputs();
    @(negedge clk);
    nChecks++;
    if (count !== 4'd0 || st_ready !== 1'b1 || mem_wr_en !== 1'b0 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_mode !== 3'b000) begin
      nFails++;
      $display("[TB] FAIL reset_state: count=%0d ready=%b wr=%b addr=%h wdata=%h mode=%b required 0/1/0/0/0/0",
               count, st_ready, mem_wr_en, mem_addr, mem_wdata, mem_mode);
    end
    clockEdge();
  endtask

  task automatic test_fill();
    doReset();
    mem_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      st_valid = 1'b1; st_addr = 32'h100 + 32'(4 * i); st_wdata = 32'(i); st_mode = 3'b010;
      @(negedge clk);
      nChecks++;
      if (st_ready !== (i < 4)) begin
        nFails++;
        $display("[TB] FAIL fill_ready_%0d: st_ready=%b required %b", i, st_ready, (i < 4));
      end
      clockEdge();
    end
    st_valid = 1'b0;
    @(negedge clk);
    nChecks++;
    if (count !== 4'd4 || st_ready !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL fill_full: count=%0d ready=%b required 4/0", count, st_ready);
    end
  endtask

  task automatic test_drain_order();
    doReset();
    mem_busy = 1'b1;
    pushStore(32'h10, 32'hA0, 3'b010);
    pushStore(32'h14, 32'hA1, 3'b010);
    pushStore(32'h18, 32'hA2, 3'b010);
    mem_busy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      nChecks++;
      if (mem_wr_en !== 1'b1 || mem_addr !== 32'h10 + 32'(4 * k) || mem_wdata !== 32'hA0 + 32'(k)) begin
        nFails++;
        $display("[TB] FAIL drain_%0d: wr=%b addr=%h wdata=%h required 1/%h/%h",
                 k, mem_wr_en, mem_addr, mem_wdata, 32'h10 + 32'(4 * k), 32'hA0 + 32'(k));
      end
      clockEdge();
    end
    @(negedge clk);
    nChecks++;
    if (count !== 4'd0 || mem_wr_en !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL drain_empty: count=%0d wr=%b required 0/0", count, mem_wr_en);
    end
  endtask

  task automatic test_overlap_stall();
    doReset();
    mem_busy = 1'b1;
    pushStore(32'h21, 32'hBEEF, 3'b001);
    ld_valid = 1'b1; ld_addr = 32'h22; ld_mode = 3'b000;
    @(negedge clk);
    nChecks++;
    if (ld_stall !== 1'b1 || fwd_valid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL overlap_22: stall=%b fwd=%b required 1/0", ld_stall, fwd_valid);
    end
    ld_addr = 32'h23;
    @(negedge clk);
    nChecks++;
    if (ld_stall !== 1'b0 || fwd_valid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL overlap_23: stall=%b fwd=%b required 0/0", ld_stall, fwd_valid);
    end
    ld_valid = 1'b0; ld_addr = 32'h22;
    @(negedge clk);
    nChecks++;
    if (ld_stall !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL overlap_noload: stall=%b required 0", ld_stall);
    end
  endtask

  task automatic test_forward();
    logic expFv, expSt;
    logic [31:0] expB, expUb;
`ifdef STORE_BUF_FWD_EN
    expFv = 1'b1; expSt = 1'b0; expB = 32'hFFFFFFF0; expUb = 32'h000000F0;
`else
    expFv = 1'b0; expSt = 1'b1; expB = 32'h0; expUb = 32'h0;
`endif
    doReset();
    mem_busy = 1'b1;
    pushStore(32'h40, 32'h000080F0, 3'b010);
    ld_valid = 1'b1; ld_addr = 32'h40; ld_mode = 3'b000;
    @(negedge clk);
    nChecks++;
    if (fwd_valid !== expFv || fwd_data !== expB || ld_stall !== expSt) begin
      nFails++;
      $display("[TB] FAIL fwd_byte: fv=%b data=%h stall=%b required %b/%h/%b",
               fwd_valid, fwd_data, ld_stall, expFv, expB, expSt);
    end
    ld_mode = 3'b011;
    @(negedge clk);
    nChecks++;
    if (fwd_valid !== expFv || fwd_data !== expUb || ld_stall !== expSt) begin
      nFails++;
      $display("[TB] FAIL fwd_ubyte: fv=%b data=%h stall=%b required %b/%h/%b",
               fwd_valid, fwd_data, ld_stall, expFv, expUb, expSt);
    end
    ld_valid = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    doReset();
    mem_busy = 1'b1;
    pushStore(32'h200, 32'h1, 3'b010);
    pushStore(32'h204, 32'h2, 3'b010);
    pushStore(32'h208, 32'h3, 3'b010);
    @(negedge clk);
    nChecks++;
    if (count !== 4'd3) begin
      nFails++;
      $display("[TB] FAIL middrain_count: count=%0d required 3", count);
    end
    mem_busy = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    nChecks++;
    if (mem_wr_en !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL middrain_rst_wr: wr=%b required 0", mem_wr_en);
    end
    clockEdge();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      nChecks++;
      if (count !== 4'd0 || mem_wr_en !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL middrain_after_%0d: count=%0d wr=%b required 0/0", k, count, mem_wr_en);
      end
      clockEdge();
    end
  endtask

  task automatic test_invalid_mode();
    doReset();
    mem_busy = 1'b0;
    st_valid = 1'b1; st_addr = 32'h300; st_wdata = 32'h55; st_mode = 3'b011;
    @(negedge clk);
    nChecks++;
    if (st_ready !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL invalid_ready: st_ready=%b required 1", st_ready);
    end
    clockEdge();
    st_valid = 1'b0;
    @(negedge clk);
    nChecks++;
    if (count !== 4'd0 || mem_wr_en !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL invalid_mode: count=%0d wr=%b required 0/0", count, mem_wr_en);
    end
  endtask

  task automatic test_random();
    logic [31:0] base;
    doReset();
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 59) == 0);
      mem_busy = ($urandom_range(0, 2) != 0);
      base     = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC : 32'h100;
      st_valid = ($urandom_range(0, 1) == 1);
      st_addr  = base + 32'($urandom_range(0, 3));
      st_wdata = $urandom;
      st_mode  = 3'($urandom_range(0, 7));
      ld_valid = ($urandom_range(0, 3) != 0);
      ld_addr  = base + 32'($urandom_range(0, 4));
      ld_mode  = 3'($urandom_range(0, 4));
      @(negedge clk);
      predict();
      nChecks++;
      if (count !== 4'(eCount) || st_ready !== eReady) begin
        nFails++;
        $display("[TB] FAIL rand_occ_%0d: count=%0d ready=%b required %0d/%b", n, count, st_ready, eCount, eReady);
      end
      nChecks++;
      if (mem_wr_en !== eWr || mem_addr !== eAddr || mem_wdata !== eData || mem_mode !== eMode) begin
        nFails++;
        $display("[TB] FAIL rand_mem_%0d: wr=%b addr=%h wdata=%h mode=%b required %b/%h/%h/%b",
                 n, mem_wr_en, mem_addr, mem_wdata, mem_mode, eWr, eAddr, eData, eMode);
      end
      nChecks++;
      if (ld_stall !== eStall || fwd_valid !== eFv || fwd_data !== eFd) begin
        nFails++;
        $display("[TB] FAIL rand_load_%0d: stall=%b fv=%b fd=%h required %b/%b/%h",
                 n, ld_stall, fwd_valid, fwd_data, eStall, eFv, eFd);
      end
      clockEdge();
    end
    rst = 1'b0;
    idleInputs();
  endtask

  initial begin
    rst = 1'b1;
    mem_busy = 1'b0;
    idleInputs();
    test_reset();
    test_fill();
    test_drain_order();
    test_overlap_stall();
    test_forward();
    test_reset_mid_drain();
    test_invalid_mode();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
